// File: rtl/vga_pkg.sv
// Shared VGA constants, Wishbone cycle-type codes and the frame reader state type.
package vga_pkg;

  localparam int DEFAULT_HDISP = 640;
  localparam int DEFAULT_VDISP = 480;

  localparam logic [2:0] CTI_INCR   = 3'b010;
  localparam logic [2:0] CTI_EOB    = 3'b111;
  localparam logic [1:0] BTE_LINEAR = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SPACE,
    BURST,
    GAP
  } frame_reader_state_t;

endpackage

// File: rtl/frame_addr_gen.sv
// Pixel counter for the frame reader: byte address of the next beat, wrap and frame_done.
module frame_addr_gen #(
  parameter int          FRAME_PIX = 640 * 480,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        advance,
  input  logic        restart,
  output logic [31:0] wb_adr,
  output logic        frame_done
);

  localparam int PIX_W = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(FRAME_PIX - 1);

  logic [PIX_W-1:0] pix_idx;
  logic             wrap_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      pix_idx    <= '0;
      wrap_d     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      // wrap_d lines up with the FIFO write of the last pixel; frame_done follows it
      wrap_d     <= advance && (pix_idx == LAST_PIX);
      frame_done <= wrap_d;
      if (restart)
        pix_idx <= '0;
      else if (advance)
        pix_idx <= (pix_idx == LAST_PIX) ? '0 : pix_idx + 1'b1;
    end
  end

  assign wb_adr = BASE_ADDR + 32'({pix_idx, 1'b0});

endmodule

// File: rtl/wshb_frame_reader.sv
// Wishbone burst-read master streaming the framebuffer into the pixel FIFO.
// Define WSHB_FRAME_READER_ERR_EN to add wb_err handling and the err_count output.
module wshb_frame_reader
  import vga_pkg::*;
#(
  parameter int          HDISP     = DEFAULT_HDISP,
  parameter int          VDISP     = DEFAULT_VDISP,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          BURST_LEN = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        enable,
  input  logic        frame_start,
  output logic [31:0] wb_adr,
  input  logic [15:0] wb_dat_sm,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [1:0]  wb_sel,
  output logic [2:0]  wb_cti,
  output logic [1:0]  wb_bte,
  input  logic        wb_ack,
  output logic [15:0] fifo_wdata,
  output logic        fifo_write,
  input  logic        fifo_walmost_full,
  output logic        frame_done
`ifdef WSHB_FRAME_READER_ERR_EN
  ,
  input  logic        wb_err,
  output logic [15:0] err_count
`endif
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
  localparam logic [BEAT_W-1:0] PENULT_BEAT = BEAT_W'((BURST_LEN > 1) ? BURST_LEN - 2 : 0);
  localparam logic [2:0]        CTI_FIRST   = (BURST_LEN == 1) ? CTI_EOB : CTI_INCR;

  frame_reader_state_t state, state_nxt;
  logic              cyc_q, cyc_nxt;
  logic [2:0]        cti_q, cti_nxt;
  logic [BEAT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic              beat_done;
  logic              restart_pend;
  logic              restart_apply;

`ifdef WSHB_FRAME_READER_ERR_EN
  // An errored beat still consumes an address and a FIFO slot so pixels stay aligned
  assign beat_done = cyc_q & (wb_ack | wb_err);
`else
  assign beat_done = cyc_q & wb_ack;
`endif

  assign restart_apply = restart_pend && (state != BURST);

  always_comb begin
    state_nxt    = state;
    cyc_nxt      = cyc_q;
    cti_nxt      = cti_q;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        if (enable)
          state_nxt = WAIT_SPACE;
      end
      WAIT_SPACE: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (!fifo_walmost_full) begin
          state_nxt    = BURST;
          cyc_nxt      = 1'b1;
          cti_nxt      = CTI_FIRST;
          beat_cnt_nxt = '0;
        end
      end
      BURST: begin
        if (beat_done) begin
          beat_cnt_nxt = beat_cnt + 1'b1;
          if (beat_cnt == PENULT_BEAT)
            cti_nxt = CTI_EOB;
          if (beat_cnt == LAST_BEAT) begin
            cyc_nxt   = 1'b0;
            state_nxt = GAP;
          end
        end
      end
      GAP: begin
        cti_nxt   = CTI_INCR;
        state_nxt = enable ? WAIT_SPACE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      cyc_q        <= 1'b0;
      cti_q        <= CTI_INCR;
      beat_cnt     <= '0;
      restart_pend <= 1'b0;
      fifo_write   <= 1'b0;
      fifo_wdata   <= 16'h0000;
    end else begin
      state        <= state_nxt;
      cyc_q        <= cyc_nxt;
      cti_q        <= cti_nxt;
      beat_cnt     <= beat_cnt_nxt;
      restart_pend <= frame_start | (restart_pend & ~restart_apply);
      fifo_write   <= beat_done;
`ifdef WSHB_FRAME_READER_ERR_EN
      fifo_wdata   <= wb_err ? 16'h0000 : wb_dat_sm;
`else
      fifo_wdata   <= wb_dat_sm;
`endif
    end
  end

`ifdef WSHB_FRAME_READER_ERR_EN
  always_ff @(posedge CLK) begin
    if (RST)
      err_count <= 16'h0000;
    else if (cyc_q && wb_err && (err_count != 16'hFFFF))
      err_count <= err_count + 16'h0001;
  end
`endif

  frame_addr_gen #(
    .FRAME_PIX (HDISP * VDISP),
    .BASE_ADDR (BASE_ADDR)
  ) u_addr_gen (
    .CLK        (CLK),
    .RST        (RST),
    .advance    (beat_done),
    .restart    (restart_apply),
    .wb_adr     (wb_adr),
    .frame_done (frame_done)
  );

  assign wb_cyc = cyc_q;
  assign wb_stb = cyc_q;
  assign wb_cti = cti_q;
  assign wb_we  = 1'b0;
  assign wb_sel = 2'b11;
  assign wb_bte = BTE_LINEAR;

endmodule

// File: tb/tb_wshb_frame_reader.sv
// Directed bench for wshb_frame_reader: 8x4 frame, 4-beat bursts, base 0x100.
module tb_wshb_frame_reader;

  localparam logic [31:0] BASE = 32'h100;
`ifdef WSHB_FRAME_READER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST, enable, frame_start, wb_ack, fifo_walmost_full;
  logic [15:0] wb_dat_sm;
  logic [31:0] wb_adr;
  logic        wb_cyc, wb_stb, wb_we, fifo_write, frame_done;
  logic [1:0]  wb_sel, wb_bte;
  logic [2:0]  wb_cti;
  logic [15:0] fifo_wdata;
`ifdef WSHB_FRAME_READER_ERR_EN
  logic        wb_err;
  logic [15:0] err_count;
`endif

  int n_checks = 0;
  int n_err    = 0;
  int cyc_cnt = 0, wr_cnt = 0, done_cnt = 0, last_wr_cyc = 0, done_cyc = 0, wr_at_done = 0;

  always #5 CLK = ~CLK;

  wshb_frame_reader #(
    .HDISP(8), .VDISP(4), .BASE_ADDR(BASE), .BURST_LEN(4)
  ) dut (
    .CLK(CLK), .RST(RST), .enable(enable), .frame_start(frame_start),
    .wb_adr(wb_adr), .wb_dat_sm(wb_dat_sm), .wb_cyc(wb_cyc), .wb_stb(wb_stb),
    .wb_we(wb_we), .wb_sel(wb_sel), .wb_cti(wb_cti), .wb_bte(wb_bte),
    .wb_ack(wb_ack), .fifo_wdata(fifo_wdata), .fifo_write(fifo_write),
    .fifo_walmost_full(fifo_walmost_full), .frame_done(frame_done)
`ifdef WSHB_FRAME_READER_ERR_EN
    , .wb_err(wb_err), .err_count(err_count)
`endif
  );

  // Write/frame_done bookkeeping, sampled on the falling edge
  always @(negedge CLK) begin
    cyc_cnt <= cyc_cnt + 1;
    if (fifo_write) begin
      wr_cnt      <= wr_cnt + 1;
      last_wr_cyc <= cyc_cnt;
    end
    if (frame_done) begin
      done_cnt   <= done_cnt + 1;
      done_cyc   <= cyc_cnt;
      wr_at_done <= wr_cnt;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pat(input logic [31:0] a);
    return a[15:0] ^ 16'hA5A5;
  endfunction

  // Services one 4-beat burst; optional wait states, frame_start pulse and error beat
  task automatic do_burst(input logic [31:0] base, input int wait_beat, input int n_wait,
                          input int fs_beat, input int err_beat);
    int t;
    logic [31:0] adr;
    logic [15:0] exp_d;
    logic err_here;
    t = 0;
    while (!wb_cyc && t < 50) begin
      @(negedge CLK);
      t++;
    end
    check("burst_start", {31'b0, wb_cyc}, 32'd1);
    if (!wb_cyc) return;
    for (int b = 0; b < 4; b++) begin
      adr = base + 32'(2 * b);
      if (b == wait_beat) begin
        for (int w = 0; w < n_wait; w++) begin
          wb_ack = 1'b0;
          check("wait_stb", {31'b0, wb_stb}, 32'd1);
          check("wait_adr", wb_adr, adr);
          if (w > 0) check("wait_no_write", {31'b0, fifo_write}, 32'd0);
          @(negedge CLK);
        end
      end
      check("adr", wb_adr, adr);
      check("cti", {29'b0, wb_cti}, (b == 3) ? 32'd7 : 32'd2);
      check("stb", {31'b0, wb_stb}, 32'd1);
      wb_dat_sm = pat(adr);
      err_here  = ERR_EN && (b == err_beat);
      exp_d     = err_here ? 16'h0000 : pat(adr);
`ifdef WSHB_FRAME_READER_ERR_EN
      if (err_here) wb_err = 1'b1;
      else          wb_ack = 1'b1;
`else
      wb_ack = 1'b1;
`endif
      if (b == fs_beat) frame_start = 1'b1;
      @(negedge CLK);
      wb_ack      = 1'b0;
      frame_start = 1'b0;
`ifdef WSHB_FRAME_READER_ERR_EN
      wb_err = 1'b0;
`endif
      check("fifo_write", {31'b0, fifo_write}, 32'd1);
      check("fifo_wdata", {16'b0, fifo_wdata}, {16'b0, exp_d});
    end
    check("gap_cyc", {31'b0, wb_cyc}, 32'd0);
  endtask

  initial begin
    int w0, d0;
    RST = 1'b1; enable = 1'b0; frame_start = 1'b0; wb_ack = 1'b0;
    wb_dat_sm = 16'h0; fifo_walmost_full = 1'b0;
`ifdef WSHB_FRAME_READER_ERR_EN
    wb_err = 1'b0;
`endif
    repeat (3) @(negedge CLK);
    check("rst_cyc", {31'b0, wb_cyc}, 32'd0);
    check("rst_stb", {31'b0, wb_stb}, 32'd0);
    check("rst_fifo_write", {31'b0, fifo_write}, 32'd0);
    check("rst_frame_done", {31'b0, frame_done}, 32'd0);
    check("rst_adr", wb_adr, 32'h100);
    check("rst_cti", {29'b0, wb_cti}, 32'd2);
    check("rst_wdata", {16'b0, fifo_wdata}, 32'd0);
    check("we", {31'b0, wb_we}, 32'd0);
    check("sel", {30'b0, wb_sel}, 32'd3);
    check("bte", {30'b0, wb_bte}, 32'd0);

    RST = 1'b0;
    repeat (3) @(negedge CLK);
    check("idle_cyc", {31'b0, wb_cyc}, 32'd0);

    fifo_walmost_full = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("full_hold_cyc", {31'b0, wb_cyc}, 32'd0);
    end
    fifo_walmost_full = 1'b0;
    @(negedge CLK);
    check("start_after_space", {31'b0, wb_cyc}, 32'd1);

    // One full frame, acked every cycle
    w0 = wr_cnt;
    d0 = done_cnt;
    for (int k = 0; k < 8; k++)
      do_burst(BASE + 32'(8 * k), -1, 0, -1, -1);
    repeat (3) @(negedge CLK);
    check("frame_writes", 32'(wr_cnt - w0), 32'd32);
    check("frame_done_count", 32'(done_cnt - d0), 32'd1);
    check("frame_done_lag", 32'(done_cyc - last_wr_cyc), 32'd1);
    check("writes_at_done", 32'(wr_at_done - w0), 32'd32);

    // Wrapped to base; three wait states on beat 2
    do_burst(BASE, 2, 3, -1, -1);
    // frame_start during beat at 0x10A: burst completes, then restart
    do_burst(BASE + 32'h8, -1, 0, 1, -1);
    d0 = done_cnt;
    do_burst(BASE, -1, 0, -1, 1);
    @(negedge CLK);
    check("no_done_on_restart", 32'(done_cnt - d0), 32'd0);
`ifdef WSHB_FRAME_READER_ERR_EN
    check("err_count", {16'b0, err_count}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
